hex_msg_reader: RTL

- Read-back direction of the board's letter-to-7-segment display path.
- Takes a four-digit frame of active-low 7-segment patterns and decodes each digit back into its 6-bit switch letter code.
- Sends the codes one at a time over a valid/ready handshake, leftmost digit (HEX3) first.
- Used to echo or transmit whatever message is currently shown on the displays.

---
 rtl/hex_msg_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hex_msg_reader.sv
// rtl/hex_msg_reader.sv - decodes a 7-segment frame back to letter codes, HEX3 first, over valid/ready
// Optional: define HEX_MSG_READER_SKIP_BLANK_EN to drop blank digits from the stream.
module hex_msg_reader #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    CLOCK_50,
  input  logic [0:1]              KEY,
  input  logic [7*NUM_DIGITS-1:0] seg_frame,
  output logic [0:5]              code_out,
  output logic                    code_valid,
  input  logic                    code_ready,
  output logic                    code_err,
  output logic [1:0]              digit_idx,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  state_t                  state, state_nx;
  logic                    key_q;
  logic                    start;
  logic [7*NUM_DIGITS-1:0] snap, snap_nx;
  logic [0:5]              code_nx;
  logic                    err_nx, valid_nx;
  logic [1:0]              idx_nx;
  logic                    load;
  logic [7*NUM_DIGITS-1:0] load_src;
  logic [1:0]              load_idx;
  logic [6:0]              dec;

  // Result is {err, code}; segment bit 0 is 'a', table patterns are written a..g.
  function automatic logic [6:0] decode(input logic [6:0] d);
    logic [6:0] p;
    p = {d[0], d[1], d[2], d[3], d[4], d[5], d[6]};
    case (p)
      7'b0001000: decode = {1'b0, 6'b100000};
      7'b1100000: decode = {1'b0, 6'b110000};
      7'b0110001: decode = {1'b0, 6'b100100};
      7'b1000010: decode = {1'b0, 6'b100110};
      7'b0110000: decode = {1'b0, 6'b100010};
      7'b0111000: decode = {1'b0, 6'b110100};
      7'b0100000: decode = {1'b0, 6'b110110};
      7'b1001000: decode = {1'b0, 6'b110010};
      7'b1001111: decode = {1'b0, 6'b010100};
      7'b1000011: decode = {1'b0, 6'b010110};
      7'b1110001: decode = {1'b0, 6'b111000};
      7'b0101011: decode = {1'b0, 6'b101100};
      7'b1101010: decode = {1'b0, 6'b101110};
      7'b0000001: decode = {1'b0, 6'b101010};
      7'b0011000: decode = {1'b0, 6'b111100};
      7'b0001100: decode = {1'b0, 6'b111110};
      7'b1111010: decode = {1'b0, 6'b111010};
      7'b0100100: decode = {1'b0, 6'b011100};
      7'b1000001: decode = {1'b0, 6'b101001};
      7'b1100011: decode = {1'b0, 6'b111001};
      7'b1010101: decode = {1'b0, 6'b011111};
      7'b1000100: decode = {1'b0, 6'b101111};
      7'b0010010: decode = {1'b0, 6'b101011};
      7'b1111111: decode = 7'b0000000;
      default:    decode = {1'b1, 6'b111111};
    endcase
  endfunction

  assign start = key_q & ~KEY[0];
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_comb begin
    state_nx = state;
    snap_nx  = snap;
    code_nx  = code_out;
    err_nx   = code_err;
    valid_nx = code_valid;
    idx_nx   = digit_idx;
    load     = 1'b0;
    load_src = snap;
    load_idx = digit_idx;
    dec      = 7'd0;
    case (state)
      IDLE: begin
        if (start) begin
          snap_nx  = seg_frame;
          load     = 1'b1;
          load_src = seg_frame;
          load_idx = LAST_IDX;
          state_nx = SEND;
        end
      end
      SEND: begin
        // code_valid low in SEND only happens while stepping over blank digits
        if (!code_valid || code_ready) begin
          if (digit_idx != 2'd0) begin
            load     = 1'b1;
            load_idx = digit_idx - 2'd1;
          end else begin
            valid_nx = 1'b0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = LAST_IDX;
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      dec     = decode(load_src[7*int'(load_idx) +: 7]);
      code_nx = dec[5:0];
      err_nx  = dec[6];
      idx_nx  = load_idx;
`ifdef HEX_MSG_READER_SKIP_BLANK_EN
      valid_nx = (dec != 7'd0);
`else
      valid_nx = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[1]) begin
      state      <= IDLE;
      key_q      <= 1'b1;
      snap       <= '0;
      code_out   <= 6'b000000;
      code_err   <= 1'b0;
      code_valid <= 1'b0;
      digit_idx  <= LAST_IDX;
    end else begin
      state      <= state_nx;
      key_q      <= KEY[0];
      snap       <= snap_nx;
      code_out   <= code_nx;
      code_err   <= err_nx;
      code_valid <= valid_nx;
      digit_idx  <= idx_nx;
    end
  end

endmodule
